puf_resp_gen: RTL and testbench
===============================

PUF_RESP_GEN -- requirements
Module: puf_resp_gen

Interface
REQ-001 Parameter CNT_BIT_SIZE, default 5, width of the ring-oscillator count sample.
REQ-002 Parameter RESP_BITS, default 8, number of response bits per challenge (one RO pair per bit).
REQ-003 Parameter N_VOTE, default 3, odd; number of A/B comparisons per bit, combined by majority vote.
REQ-004 Parameter TIMEOUT, default 1023, maximum MEAS-state cycles before abort.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 i_start  in  1  single-cycle request; starts a response generation.
REQ-009 i_count_valid  in  1  counter-done level from the RO counter (asynchronous to clk).
REQ-010 i_count  in  CNT_BIT_SIZE  count sample; stable while i_count_valid is high.
REQ-011 i_resp_ready  in  1  consumer accepts o_resp.
REQ-012 o_ro_en  out  1  enables the selected oscillator and counter.
REQ-013 o_ro_rst_n  out  1  active-low counter reset, driven to the RO counter.
REQ-014 o_ro_sel  out  1  0 = oscillator A, 1 = oscillator B of the current pair.
REQ-015 o_pair_idx  out  clog2(RESP_BITS)  current RO pair index.
REQ-016 o_resp  out  RESP_BITS  response word; bit k comes from pair k.
REQ-017 o_resp_valid  out  1  o_resp is available.
REQ-018 o_busy  out  1  high in every state except IDLE and ERR.
REQ-019 o_tie  out  1  sticky; at least one comparison had A == B.
REQ-020 o_err  out  1  sticky; a measurement timeout occurred.

Function
REQ-021 i_count_valid SHALL pass through a 2-flop synchronizer; the rising edge of the synchronized signal is the capture event.
REQ-022 The FSM SHALL have the states IDLE, RST_RO, MEAS, OUT and ERR.
REQ-023 IDLE: o_ro_rst_n=0 and o_ro_en=0; i_start moves to RST_RO and clears o_resp, o_tie, o_pair_idx, the vote counters and o_ro_sel.
REQ-024 RST_RO: o_ro_rst_n=0 and o_ro_en=0 for exactly 2 cycles, then MEAS.
REQ-025 MEAS: o_ro_rst_n=1 and o_ro_en=1; on the capture event, the next cycle latches i_count into reg A (sel=0) or reg B (sel=1).
REQ-026 After an A capture: sel becomes 1 and the FSM goes to RST_RO.
REQ-027 After a B capture: sel becomes 0; vote bit = (A > B), unsigned compare; A == B gives vote 0 and sets o_tie; the ones-counter and the vote index are updated.
REQ-028 When the vote index reaches N_VOTE: o_resp[o_pair_idx] = (ones > N_VOTE/2); then the vote counters clear and o_pair_idx increments.
REQ-029 If o_pair_idx was RESP_BITS-1 at that point, the FSM goes to OUT; otherwise it goes to RST_RO.
REQ-030 OUT: o_resp_valid=1 and o_resp held stable until i_resp_ready=1; the handshake completes in that cycle and the FSM returns to IDLE the next cycle.
REQ-031 A MEAS-cycle counter SHALL reset on entry to MEAS; if it reaches TIMEOUT with no capture event, the FSM goes to ERR.
REQ-032 ERR: o_err=1, o_ro_en=0, o_ro_rst_n=0; i_start clears o_err and behaves as in IDLE.
REQ-033 i_start SHALL be ignored in RST_RO, MEAS and OUT.
REQ-034 The vote counter SHALL be clog2(N_VOTE+1) bits and SHALL never wrap; the MEAS counter SHALL saturate at TIMEOUT.

Reset
REQ-035 rst SHALL force IDLE in the next cycle from any state, including mid-measurement and mid-handshake.
REQ-036 Reset values: o_resp=0, o_resp_valid=0, o_busy=0, o_tie=0, o_err=0, o_ro_en=0, o_ro_rst_n=0, o_ro_sel=0, o_pair_idx=0; synchronizer flops=0.

Structure
REQ-037 A shared package puf_pkg SHALL hold the FSM state encoding and the default values of CNT_BIT_SIZE and RESP_BITS.
REQ-038 The synchronizer and edge detector SHALL be the sub-module puf_sync2; all other logic is flat.

Verification
REQ-039 Reset: assert rst for 3 cycles in MEAS -> all outputs at REQ-036 values one cycle later.
REQ-040 Counter model gives A=20, B=12 for even pairs and A=10, B=15 for odd pairs; RESP_BITS=8, N_VOTE=3 -> o_resp=8'h55, o_tie=0, o_err=0.
REQ-041 Pair 0 votes 1,0,1 -> o_resp[0]=1; pair 1 votes 0,0,1 -> o_resp[1]=0.
REQ-042 Pair 3 gives A=B=9 for all votes -> o_resp[3]=0 and o_tie=1, held until the next i_start.
REQ-043 i_count_valid stuck low -> o_err=1 exactly TIMEOUT cycles after MEAS entry, o_ro_en=0; next i_start -> o_err=0 and a new run completes.
REQ-044 i_resp_ready low for 10 cycles in OUT, plus an i_start pulse during OUT -> o_resp stable, o_resp_valid held, start ignored; ready=1 -> IDLE the next cycle.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response generator: FSM state encoding,
// default datapath sizes and the majority-vote helper.
package puf_pkg;

  localparam int CNT_BIT_SIZE_DEF = 5;
  localparam int RESP_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST_RO = 3'd1,
    ST_MEAS   = 3'd2,
    ST_OUT    = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // A response bit is 1 when strictly more than half of the votes were 1.
  function automatic logic majority(input int ones, input int n_vote);
    return (ones > (n_vote / 2)) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/puf_resp_gen_if.sv
// Response handshake between the PUF response generator (master) and its
// consumer (slave).
interface puf_resp_gen_if #(
  parameter int RESP_BITS = puf_pkg::RESP_BITS_DEF
) ();

  logic [RESP_BITS-1:0] o_resp;
  logic                 o_resp_valid;
  logic                 i_resp_ready;

  modport master (output o_resp, output o_resp_valid, input i_resp_ready);
  modport slave  (input o_resp, input o_resp_valid, output i_resp_ready);

endinterface

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for the asynchronous counter-done level, followed by
// a rising-edge detector that marks the capture event.
module puf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/puf_resp_gen.sv
// Ring-oscillator PUF response generator. For every RO pair it measures
// oscillator A and B N_VOTE times, votes (A > B) per measurement and takes
// the majority as the response bit. The RO counter is reset between every
// single measurement; a stuck counter aborts the run into ERR.
module puf_resp_gen
  import puf_pkg::*;
#(
  parameter int CNT_BIT_SIZE = CNT_BIT_SIZE_DEF,
  parameter int RESP_BITS    = RESP_BITS_DEF,
  parameter int N_VOTE       = 3,
  parameter int TIMEOUT      = 1023,
  localparam int PW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1,
  localparam int VW = $clog2(N_VOTE + 1),
  localparam int MW = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_count_valid,
  input  logic [CNT_BIT_SIZE-1:0] i_count,
  output logic                    o_ro_en,
  output logic                    o_ro_rst_n,
  output logic                    o_ro_sel,
  output logic [PW-1:0]           o_pair_idx,
  output logic                    o_busy,
  output logic                    o_tie,
  output logic                    o_err,
  puf_resp_gen_if.master          resp_bus
);

  state_t                  state, state_nx;
  logic [CNT_BIT_SIZE-1:0] cnt_a, cnt_a_nx;
  logic                    sel, sel_nx;
  logic [PW-1:0]           pair, pair_nx;
  logic [VW-1:0]           vote_idx, vote_idx_nx;
  logic [VW-1:0]           ones, ones_nx;
  logic [VW-1:0]           ones_inc;
  logic [RESP_BITS-1:0]    resp, resp_nx;
  logic                    tie, tie_nx;
  logic                    err, err_nx;
  logic [MW-1:0]           meas_cnt, meas_cnt_nx;
  logic                    rst_cnt, rst_cnt_nx;
  logic                    ro_en, ro_en_nx;
  logic                    ro_rst_n, ro_rst_n_nx;
  logic                    busy, busy_nx;
  logic                    resp_valid, resp_valid_nx;
  logic                    vote;
  logic                    cap;
  logic                    last_pair;

  puf_sync2 u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (i_count_valid),
    .rise (cap)
  );

  assign last_pair = (pair == PW'(RESP_BITS - 1));

  // Next-state, datapath and registered-output decode for the measurement FSM.
  always_comb begin
    state_nx    = state;
    cnt_a_nx    = cnt_a;
    sel_nx      = sel;
    pair_nx     = pair;
    vote_idx_nx = vote_idx;
    ones_nx     = ones;
    resp_nx     = resp;
    tie_nx      = tie;
    err_nx      = err;
    meas_cnt_nx = meas_cnt;
    rst_cnt_nx  = rst_cnt;
    vote        = 1'b0;
    ones_inc    = ones;

    case (state)
      ST_IDLE, ST_ERR: begin
        if (i_start) begin
          state_nx    = ST_RST_RO;
          resp_nx     = '0;
          tie_nx      = 1'b0;
          err_nx      = 1'b0;
          pair_nx     = '0;
          vote_idx_nx = '0;
          ones_nx     = '0;
          sel_nx      = 1'b0;
          rst_cnt_nx  = 1'b0;
        end else begin
          state_nx = state;
        end
      end

      ST_RST_RO: begin
        // The MEAS timeout counter restarts on every entry to MEAS.
        meas_cnt_nx = '0;
        if (rst_cnt) begin
          state_nx   = ST_MEAS;
          rst_cnt_nx = 1'b0;
        end else begin
          rst_cnt_nx = 1'b1;
        end
      end

      ST_MEAS: begin
        if (cap) begin
          rst_cnt_nx = 1'b0;
          state_nx   = ST_RST_RO;
          if (!sel) begin
            cnt_a_nx = i_count;
            sel_nx   = 1'b1;
          end else begin
            // The B sample is compared directly as it is captured.
            sel_nx   = 1'b0;
            vote     = (cnt_a > i_count) ? 1'b1 : 1'b0;
            ones_inc = ones + VW'(vote);
            if (cnt_a == i_count) begin
              tie_nx = 1'b1;
            end else begin
              tie_nx = tie;
            end
            if (vote_idx == VW'(N_VOTE - 1)) begin
              resp_nx[pair] = majority(int'(ones_inc), N_VOTE);
              vote_idx_nx   = '0;
              ones_nx       = '0;
              if (last_pair) begin
                pair_nx  = '0;
                state_nx = ST_OUT;
              end else begin
                pair_nx  = pair + PW'(1);
              end
            end else begin
              vote_idx_nx = vote_idx + VW'(1);
              ones_nx     = ones_inc;
            end
          end
        end else if (meas_cnt == MW'(TIMEOUT - 1)) begin
          meas_cnt_nx = MW'(TIMEOUT);
          err_nx      = 1'b1;
          state_nx    = ST_ERR;
        end else begin
          meas_cnt_nx = meas_cnt + MW'(1);
        end
      end

      ST_OUT: begin
        if (resp_bus.i_resp_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_OUT;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    ro_en_nx      = (state_nx == ST_MEAS);
    ro_rst_n_nx   = (state_nx == ST_MEAS);
    resp_valid_nx = (state_nx == ST_OUT);
    busy_nx       = (state_nx == ST_RST_RO) || (state_nx == ST_MEAS) ||
                    (state_nx == ST_OUT);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt_a      <= '0;
      sel        <= 1'b0;
      pair       <= '0;
      vote_idx   <= '0;
      ones       <= '0;
      resp       <= '0;
      tie        <= 1'b0;
      err        <= 1'b0;
      meas_cnt   <= '0;
      rst_cnt    <= 1'b0;
      ro_en      <= 1'b0;
      ro_rst_n   <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt_a      <= cnt_a_nx;
      sel        <= sel_nx;
      pair       <= pair_nx;
      vote_idx   <= vote_idx_nx;
      ones       <= ones_nx;
      resp       <= resp_nx;
      tie        <= tie_nx;
      err        <= err_nx;
      meas_cnt   <= meas_cnt_nx;
      rst_cnt    <= rst_cnt_nx;
      ro_en      <= ro_en_nx;
      ro_rst_n   <= ro_rst_n_nx;
      busy       <= busy_nx;
      resp_valid <= resp_valid_nx;
    end
  end

  assign o_ro_en               = ro_en;
  assign o_ro_rst_n            = ro_rst_n;
  assign o_ro_sel              = sel;
  assign o_pair_idx            = pair;
  assign o_busy                = busy;
  assign o_tie                 = tie;
  assign o_err                 = err;
  assign resp_bus.o_resp       = resp;
  assign resp_bus.o_resp_valid = resp_valid;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Scoreboard bench for puf_resp_gen: a behavioural RO counter feeds directed
// A/B counts, expected responses are queued at start and checked by a
// monitor at every completed response handshake.
module tb_puf_resp_gen;

  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       count_valid;
  logic [4:0] count;
  logic       ro_en, ro_rst_n, ro_sel, busy, tie, err;
  logic [2:0] pair_idx;

  typedef struct packed {
    logic [7:0] resp;
    logic       tie;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  logic [7:0] pat = 8'h00;
  int         mode = 0;   // 0 plain, 1 mixed votes/tie, 2 extremes, 3 stuck
  int         meas_no;
  int         t0;
  logic       found;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  puf_resp_gen_if #(.RESP_BITS(8)) bus ();

  puf_resp_gen #(
    .CNT_BIT_SIZE (5),
    .RESP_BITS    (8),
    .N_VOTE       (3),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_count_valid (count_valid),
    .i_count       (count),
    .o_ro_en       (ro_en),
    .o_ro_rst_n    (ro_rst_n),
    .o_ro_sel      (ro_sel),
    .o_pair_idx    (pair_idx),
    .o_busy        (busy),
    .o_tie         (tie),
    .o_err         (err),
    .resp_bus      (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Count seen for measurement m (6 per pair: A,B for each of 3 votes).
  function automatic logic [4:0] ro_value(input int m, input logic [7:0] p, input int md);
    int         k;
    int         vt;
    logic [4:0] a;
    logic [4:0] b;
    k  = (m / 6) % 8;
    vt = (m % 6) / 2;
    if (md == 2) begin
      a = p[k] ? 5'd31 : 5'd0;
      b = p[k] ? 5'd0 : 5'd31;
    end else begin
      a = p[k] ? 5'd20 : 5'd10;
      b = p[k] ? 5'd12 : 5'd15;
      if (md == 1) begin
        if (k == 0 && vt == 1) begin a = 5'd5;  b = 5'd7;  end
        if (k == 1 && vt == 2) begin a = 5'd15; b = 5'd10; end
        if (k == 3)            begin a = 5'd9;  b = 5'd9;  end
      end
    end
    return ((m % 2) == 1) ? b : a;
  endfunction

  // Behavioural RO counter: done a few cycles after enable, cleared by ro_rst_n.
  initial begin
    int dly;
    count_valid = 1'b0;
    count       = 5'd0;
    meas_no     = 0;
    dly         = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) meas_no = 0;
      if (!ro_rst_n || !ro_en) begin
        count_valid = 1'b0;
        dly         = 0;
      end else if (!count_valid && mode != 3) begin
        dly++;
        if (dly >= 4) begin
          count       = ro_value(meas_no, pat, mode);
          count_valid = 1'b1;
          meas_no++;
        end
      end
    end
  end

  // Monitor: compare every completed response handshake with the scoreboard.
  always @(negedge clk) begin
    if (bus.o_resp_valid && bus.i_resp_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_resp: got %0h, expected no response", bus.o_resp);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp", 32'(bus.o_resp), 32'(mon_e.resp));
        check("tie", 32'(tie), 32'(mon_e.tie));
        check("err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_rst(input string name);
    check(name, 32'({bus.o_resp, bus.o_resp_valid, busy, tie, err, ro_en, ro_rst_n,
                     ro_sel, pair_idx}), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_ro_en(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ro_en) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_meas"}, 32'(ok), 32'd1);
  endtask

  task automatic run(input logic [7:0] p, input int md, input logic [7:0] er,
                     input logic et, input string name);
    pat  = p;
    mode = md;
    sb_q.push_back(exp_t'{resp: er, tie: et, err: 1'b0});
    pulse_start();
    wait_idle(name);
  endtask

  initial begin
    rst              = 1'b1;
    start            = 1'b0;
    bus.i_resp_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_rst("reset_init");
    tick();
    rst = 1'b0;

    run(8'h55, 0, 8'h55, 1'b0, "run_basic");
    run(8'h55, 1, 8'h55, 1'b1, "run_mixed_tie");
    repeat (5) @(negedge clk);
    check("tie_sticky", 32'(tie), 32'd1);

    pat  = 8'hA3;
    mode = 0;
    sb_q.push_back(exp_t'{resp: 8'hA3, tie: 1'b0, err: 1'b0});
    pulse_start();
    @(negedge clk);
    check("tie_cleared", 32'(tie), 32'd0);
    wait_idle("run_a3");

    run(8'h3C, 2, 8'h3C, 1'b0, "run_extreme");

    // Consumer stalls for 10 cycles in OUT; a start pulse arrives meanwhile.
    bus.i_resp_ready = 1'b0;
    pat  = 8'h96;
    mode = 0;
    sb_q.push_back(exp_t'{resp: 8'h96, tie: 1'b0, err: 1'b0});
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.o_resp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("out_reached", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      start = (i == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("hold_resp", 32'(bus.o_resp), 32'h96);
      check("hold_valid", 32'({bus.o_resp_valid, busy}), 32'd3);
    end
    tick();
    start            = 1'b0;
    bus.i_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("out_exit", 32'({busy, bus.o_resp_valid}), 32'd0);

    // Reset held for 3 cycles in the middle of a measurement.
    pat  = 8'h55;
    mode = 0;
    pulse_start();
    wait_ro_en("rst_run");
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_rst("reset_mid_meas");
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_rst("reset_released");

    // Counter never finishes: timeout into ERR.
    mode = 3;
    pulse_start();
    wait_ro_en("to_run");
    t0    = cyc;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (err) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("timeout_seen", 32'(found), 32'd1);
    check("timeout_cycles", 32'(cyc - t0), 32'(TIMEOUT));
    check("err_outputs", 32'({ro_en, ro_rst_n, busy}), 32'd0);

    // Recovery from ERR with a new start.
    pat  = 8'h55;
    mode = 0;
    sb_q.push_back(exp_t'{resp: 8'h55, tie: 1'b0, err: 1'b0});
    pulse_start();
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    wait_idle("run_recover");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
